// File: rtl/ts_pkt_arb4.sv
// ts_pkt_arb4: packet-level round-robin arbiter sharing one 32-bit TS stream among four sources.
// Optional build macro TS_ARB_CC_RESTAMP_EN restamps the continuity nibble of output word 2 per source.
module ts_pkt_arb4 #(
    parameter int U_DLY      = 1,
    parameter int PKT_WORDS  = 48,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   pkt_req,
    output logic [3:0]   pkt_gnt,
    input  logic [3:0]   in_sync,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_eop,
    input  logic [127:0] in_data,
    output logic         out_sync,
    output logic         out_valid,
    output logic         out_eop,
    output logic [31:0]  out_data,
    output logic [1:0]   cur_src,
    output logic         busy,
    output logic         err_len,
    output logic         err_tmo
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    localparam logic [7:0] LAST_IDX = 8'(PKT_WORDS - 1);
    localparam logic [7:0] TMO_IDX  = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_IDX  = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

    state_t      state_reg, state_next;
    logic [1:0]  cur_src_reg, cur_src_next;
    logic [1:0]  last_reg, last_next;
    logic [7:0]  wcnt_reg, wcnt_next;
    logic [7:0]  stall_reg, stall_next;
    logic [7:0]  gap_reg, gap_next;
    logic [3:0]  gnt_reg, gnt_next;

    logic        out_sync_reg, out_valid_reg, out_eop_reg;
    logic [31:0] out_data_reg;
    logic        err_len_reg, err_tmo_reg;

    logic        win_found;
    logic [1:0]  win_idx;
    logic        word_acc, pkt_done, tmo_hit;
    logic        sel_sync, sel_valid, sel_eop, frame_err;
    logic [31:0] sel_data, word_data;

    // The delay parameter exists only for simulation models upstream; it has no hardware meaning.
    logic unused_dly;
    assign unused_dly = ^U_DLY;

    assign sel_sync  = in_sync[cur_src_reg];
    assign sel_valid = in_valid[cur_src_reg];
    assign sel_eop   = in_eop[cur_src_reg];
    assign sel_data  = in_data[32*cur_src_reg +: 32];

    // Framing is judged against our own word count, never against the source's strobes.
    assign frame_err = ((wcnt_reg == 8'd0) != sel_sync) || ((wcnt_reg == LAST_IDX) != sel_eop);

`ifdef TS_ARB_CC_RESTAMP_EN
    logic [15:0] cc_vec;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cc
        logic [3:0] cc_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cc_reg <= 4'd0;
            end else if (pkt_done && (cur_src_reg == 2'(gi))) begin
                cc_reg <= cc_reg + 4'd1;
            end
        end

        assign cc_vec[4*gi +: 4] = cc_reg;
    end

    always_comb begin
        word_data = sel_data;
        if (wcnt_reg == 8'd1) begin
            word_data[3:0] = cc_vec[4*cur_src_reg +: 4];
        end
    end
`else
    assign word_data = sel_data;
`endif

    // Round-robin search starting one past the last granted source; 2-bit index wraps mod 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && pkt_req[last_reg + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = last_reg + 2'(k);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_src_next = cur_src_reg;
        last_next    = last_reg;
        wcnt_next    = wcnt_reg;
        stall_next   = stall_reg;
        gap_next     = gap_reg;
        gnt_next     = 4'b0000;
        word_acc     = 1'b0;
        pkt_done     = 1'b0;
        tmo_hit      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    cur_src_next = win_idx;
                    gnt_next     = 4'b0001 << win_idx;
                    state_next   = GRANT;
                end
            end
            GRANT: begin
                wcnt_next  = 8'd0;
                stall_next = 8'd0;
                last_next  = cur_src_reg;
                state_next = XFER;
            end
            XFER: begin
                if (sel_valid) begin
                    word_acc   = 1'b1;
                    stall_next = 8'd0;
                    wcnt_next  = wcnt_reg + 8'd1;
                    if (wcnt_reg == LAST_IDX) begin
                        pkt_done   = 1'b1;
                        gap_next   = 8'd0;
                        state_next = HAS_GAP ? GAP : IDLE;
                    end
                end else if (stall_reg == TMO_IDX) begin
                    // Abort leaves the output packet truncated without an eop.
                    tmo_hit    = 1'b1;
                    gap_next   = 8'd0;
                    state_next = HAS_GAP ? GAP : IDLE;
                end else begin
                    stall_next = stall_reg + 8'd1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_IDX) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_src_reg   <= 2'd0;
            last_reg      <= 2'd3;
            wcnt_reg      <= 8'd0;
            stall_reg     <= 8'd0;
            gap_reg       <= 8'd0;
            gnt_reg       <= 4'b0000;
            out_sync_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_eop_reg   <= 1'b0;
            out_data_reg  <= 32'h0;
            err_len_reg   <= 1'b0;
            err_tmo_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_src_reg   <= cur_src_next;
            last_reg      <= last_next;
            wcnt_reg      <= wcnt_next;
            stall_reg     <= stall_next;
            gap_reg       <= gap_next;
            gnt_reg       <= gnt_next;
            out_sync_reg  <= word_acc && (wcnt_reg == 8'd0);
            out_valid_reg <= word_acc;
            out_eop_reg   <= word_acc && (wcnt_reg == LAST_IDX);
            out_data_reg  <= word_acc ? word_data : 32'h0;
            err_len_reg   <= word_acc && frame_err;
            err_tmo_reg   <= tmo_hit;
        end
    end

    assign pkt_gnt   = gnt_reg;
    assign out_sync  = out_sync_reg;
    assign out_valid = out_valid_reg;
    assign out_eop   = out_eop_reg;
    assign out_data  = out_data_reg;
    assign cur_src   = cur_src_reg;
    assign busy      = (state_reg != IDLE);
    assign err_len   = err_len_reg;
    assign err_tmo   = err_tmo_reg;

endmodule

// File: tb/tb_ts_pkt_arb4.sv
// Directed bench for ts_pkt_arb4: instance A (no gap, TIMEOUT=8) and instance B (GAP_CYCLES=5) share stimulus.
module tb_ts_pkt_arb4;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   pkt_req  = 4'b0;
    logic [3:0]   in_sync  = 4'b0;
    logic [3:0]   in_valid = 4'b0;
    logic [3:0]   in_eop   = 4'b0;
    logic [127:0] in_data  = 128'h0;

    logic [3:0]  a_gnt, b_gnt;
    logic        a_sync, a_valid, a_eop, b_sync, b_valid, b_eop;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_cur, b_cur;
    logic        a_busy, b_busy, a_err_len, b_err_len, a_err_tmo, b_err_tmo;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

`ifdef TS_ARB_CC_RESTAMP_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ts_pkt_arb4 #(.U_DLY(1), .PKT_WORDS(48), .GAP_CYCLES(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .pkt_req(pkt_req), .pkt_gnt(a_gnt),
        .in_sync(in_sync), .in_valid(in_valid), .in_eop(in_eop), .in_data(in_data),
        .out_sync(a_sync), .out_valid(a_valid), .out_eop(a_eop), .out_data(a_data),
        .cur_src(a_cur), .busy(a_busy), .err_len(a_err_len), .err_tmo(a_err_tmo)
    );

    ts_pkt_arb4 #(.U_DLY(1), .PKT_WORDS(48), .GAP_CYCLES(5), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst(rst), .pkt_req(pkt_req), .pkt_gnt(b_gnt),
        .in_sync(in_sync), .in_valid(in_valid), .in_eop(in_eop), .in_data(in_data),
        .out_sync(b_sync), .out_valid(b_valid), .out_eop(b_eop), .out_data(b_data),
        .cur_src(b_cur), .busy(b_busy), .err_len(b_err_len), .err_tmo(b_err_tmo)
    );

    // Output recorder, sampled on the falling edge
    int a_words, a_first_cyc, a_sync_cnt, a_sync_pos, a_eop_cnt, a_eop_pos, a_eop_cyc;
    int a_errlen_cnt, a_errlen_pos, a_tmo_cnt, a_tmo_cyc, a_gnt_cnt, a_idle_nz;
    logic [31:0] a_data_log [256];
    int b_eop_cyc;

    always @(negedge clk) begin
        if (a_gnt != 4'b0) a_gnt_cnt++;
        if (a_valid) begin
            if (a_words == 0) a_first_cyc = cyc;
            if (a_sync) begin a_sync_cnt++; a_sync_pos = a_words + 1; end
            if (a_eop) begin a_eop_cnt++; a_eop_pos = a_words + 1; a_eop_cyc = cyc; end
            if (a_err_len) begin a_errlen_cnt++; a_errlen_pos = a_words + 1; end
            if (a_words < 256) a_data_log[a_words] = a_data;
            a_words++;
        end else begin
            if (a_err_len) a_errlen_cnt++;
            if (a_data != 32'h0 || a_sync || a_eop) a_idle_nz++;
        end
        if (a_err_tmo) begin a_tmo_cnt++; a_tmo_cyc = cyc; end
        if (b_eop) b_eop_cyc = cyc;
    end

    task automatic clear_mon();
        a_words = 0; a_first_cyc = -1; a_sync_cnt = 0; a_sync_pos = -1; a_eop_cnt = 0;
        a_eop_pos = -1; a_eop_cyc = -1; a_errlen_cnt = 0; a_errlen_pos = -1;
        a_tmo_cnt = 0; a_tmo_cyc = -1; a_gnt_cnt = 0; a_idle_nz = 0; b_eop_cyc = -1;
    endtask

    function automatic logic [31:0] exp_word(input int src, input int tag, input int w);
        return {4'(src), 4'h0, 8'(tag), 8'(w), 8'h5F};
    endfunction

    function automatic logic [31:0] exp_out(input int src, input int tag, input int w, input int cc);
        logic [31:0] v;
        v = exp_word(src, tag, w);
        if (CC_ON && w == 2) v[3:0] = 4'(cc);
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pkt_req = 4'b0; in_sync = 4'b0; in_valid = 4'b0; in_eop = 4'b0; in_data = 128'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_gnt(input bit use_b, output logic [3:0] g, output int gcyc);
        bit got;
        got = 1'b0; g = 4'b0; gcyc = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (!use_b && a_gnt != 4'b0) begin got = 1'b1; g = a_gnt; gcyc = cyc; end
            if (use_b && b_gnt != 4'b0) begin got = 1'b1; g = b_gnt; gcyc = cyc; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL gnt_wait: no grant within 300 cycles (dut %s), required a grant", use_b ? "B" : "A");
        end
    endtask

    // Drives nwords on lane src starting next cycle; bad_eop adds a premature eop on that word.
    task automatic send_packet(input int src, input int tag, input int nwords, input int bad_eop, output int last_cyc);
        last_cyc = -1;
        for (int w = 1; w <= nwords; w++) begin
            @(posedge clk); #1;
            in_valid[src] = 1'b1;
            in_sync[src]  = (w == 1);
            in_eop[src]   = (w == 48) || (w == bad_eop);
            in_data[32*src +: 32] = exp_word(src, tag, w);
            last_cyc = cyc;
        end
        @(posedge clk); #1;
        in_valid[src] = 1'b0; in_sync[src] = 1'b0; in_eop[src] = 1'b0;
        in_data[32*src +: 32] = 32'h0;
        $display("pkt src=%0d tag=%0d words=%0d last_in_cyc=%0d", src, tag, nwords, last_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_req = 4'hF; in_valid = 4'hF; in_sync = 4'hF; in_eop = 4'hF; in_data = {4{32'hFFFF_FFFF}};
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (a_gnt !== 4'b0) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", a_gnt); end
        n_vec++; if ({a_sync, a_valid, a_eop} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {a_sync, a_valid, a_eop}); end
        n_vec++; if (a_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", a_data); end
        n_vec++; if (a_cur !== 2'd0 || a_busy !== 1'b0) begin n_err++; $display("FAIL rst_cur_busy: got %0d/%b want 0/0", a_cur, a_busy); end
        n_vec++; if ({a_err_len, a_err_tmo, b_busy} !== 3'b000) begin n_err++; $display("FAIL rst_err: got %b want 000", {a_err_len, a_err_tmo, b_busy}); end
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (a_busy !== 1'b0 || a_gnt !== 4'b0) begin n_err++; $display("FAIL idle_noreq: busy=%b gnt=%b want 0/0000", a_busy, a_gnt); end
    endtask

    task automatic test_single();
        logic [3:0] g; int gcyc, lc, rcyc, bad;
        do_reset(); clear_mon();
        @(posedge clk); #1;
        pkt_req = 4'b0001; rcyc = cyc;
        wait_gnt(1'b0, g, gcyc);
        pkt_req = 4'b0;
        in_valid[3] = 1'b1; in_sync[3] = 1'b1; in_eop[3] = 1'b1; in_data[127:96] = 32'hDEAD_BEEF;
        n_vec++; if (g !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", g); end
        n_vec++; if (gcyc != rcyc + 1) begin n_err++; $display("FAIL single_gnt_lat: got %0d want %0d", gcyc - rcyc, 1); end
        send_packet(0, 1, 48, 0, lc);
        in_valid[3] = 1'b0; in_sync[3] = 1'b0; in_eop[3] = 1'b0; in_data[127:96] = 32'h0;
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", a_busy); end
        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int w = 1; w <= 48; w++) if (a_data_log[w-1] !== exp_out(0, 1, w, 0)) bad++;
        n_vec++; if (a_gnt_cnt != 1) begin n_err++; $display("FAIL single_gnt_width: got %0d want 1", a_gnt_cnt); end
        n_vec++; if (a_words != 48) begin n_err++; $display("FAIL single_words: got %0d want 48", a_words); end
        n_vec++; if (a_first_cyc != gcyc + 2) begin n_err++; $display("FAIL single_first_lat: got %0d want %0d", a_first_cyc, gcyc + 2); end
        n_vec++; if (a_sync_cnt != 1 || a_sync_pos != 1) begin n_err++; $display("FAIL single_sync: got cnt=%0d pos=%0d want 1/1", a_sync_cnt, a_sync_pos); end
        n_vec++; if (a_eop_cnt != 1 || a_eop_pos != 48) begin n_err++; $display("FAIL single_eop: got cnt=%0d pos=%0d want 1/48", a_eop_cnt, a_eop_pos); end
        n_vec++; if (a_eop_cyc != lc + 1) begin n_err++; $display("FAIL single_eop_lat: got %0d want %0d", a_eop_cyc, lc + 1); end
        n_vec++; if (a_errlen_cnt != 0 || a_tmo_cnt != 0) begin n_err++; $display("FAIL single_err: got len=%0d tmo=%0d want 0/0", a_errlen_cnt, a_tmo_cnt); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL single_data: got %0d bad words want 0", bad); end
        n_vec++; if (a_idle_nz != 0) begin n_err++; $display("FAIL single_idle_out: got %0d nonzero idle cycles want 0", a_idle_nz); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g; int gcyc, lc, bad;
        int order [5] = '{0, 1, 2, 3, 0};
        int cc_exp [4] = '{0, 0, 0, 0};
        do_reset(); clear_mon();
        @(posedge clk); #1;
        pkt_req = 4'b1111;
        lc = -1; bad = 0;
        for (int p = 0; p < 5; p++) begin
            wait_gnt(1'b0, g, gcyc);
            if (p == 4) pkt_req = 4'b0;
            n_vec++; if (g !== 4'(1 << order[p])) begin n_err++; $display("FAIL b2b_order%0d: got %b want %b", p, g, 4'(1 << order[p])); end
            n_vec++; if (a_cur !== 2'(order[p])) begin n_err++; $display("FAIL b2b_cur%0d: got %0d want %0d", p, a_cur, order[p]); end
            if (p > 0) begin
                n_vec++; if (gcyc != lc + 2) begin n_err++; $display("FAIL b2b_gap%0d: got %0d want 2", p, gcyc - lc); end
            end
            send_packet(order[p], p, 48, 0, lc);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) begin
            for (int w = 1; w <= 48; w++)
                if (a_data_log[p*48 + w - 1] !== exp_out(order[p], p, w, cc_exp[order[p]])) bad++;
            cc_exp[order[p]]++;
        end
        n_vec++; if (a_words != 240 || a_eop_cnt != 5 || a_sync_cnt != 5) begin n_err++; $display("FAIL b2b_counts: got words=%0d eop=%0d sync=%0d want 240/5/5", a_words, a_eop_cnt, a_sync_cnt); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_data: got %0d bad words want 0", bad); end
    endtask

    task automatic test_len_err();
        logic [3:0] g; int gcyc, lc;
        do_reset(); clear_mon();
        @(posedge clk); #1;
        pkt_req = 4'b0010;
        wait_gnt(1'b0, g, gcyc);
        pkt_req = 4'b0;
        send_packet(1, 7, 48, 30, lc);
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (a_errlen_cnt != 1 || a_errlen_pos != 30) begin n_err++; $display("FAIL len_err: got cnt=%0d pos=%0d want 1/30", a_errlen_cnt, a_errlen_pos); end
        n_vec++; if (a_words != 48 || a_eop_cnt != 1 || a_eop_pos != 48) begin n_err++; $display("FAIL len_err_eop: got words=%0d eop=%0d pos=%0d want 48/1/48", a_words, a_eop_cnt, a_eop_pos); end
    endtask

    task automatic test_timeout();
        logic [3:0] g; int gcyc, lc;
        do_reset(); clear_mon();
        @(posedge clk); #1;
        pkt_req = 4'b0100;
        wait_gnt(1'b0, g, gcyc);
        pkt_req = 4'b0;
        send_packet(2, 3, 10, 0, lc);
        pkt_req = 4'b1000;
        wait_gnt(1'b0, g, gcyc);
        pkt_req = 4'b0;
        n_vec++; if (a_tmo_cnt != 1 || a_tmo_cyc != lc + 9) begin n_err++; $display("FAIL tmo_pulse: got cnt=%0d at +%0d want 1 at +9", a_tmo_cnt, a_tmo_cyc - lc); end
        n_vec++; if (a_eop_cnt != 0 || a_words != 10 || a_errlen_cnt != 0) begin n_err++; $display("FAIL tmo_trunc: got eop=%0d words=%0d len=%0d want 0/10/0", a_eop_cnt, a_words, a_errlen_cnt); end
        n_vec++; if (g !== 4'b1000 || gcyc != lc + 10) begin n_err++; $display("FAIL tmo_regrant: got %b at +%0d want 1000 at +10", g, gcyc - lc); end
    endtask

    task automatic test_gap();
        logic [3:0] g; int gcyc, lc;
        do_reset(); clear_mon();
        @(posedge clk); #1;
        pkt_req = 4'b0011;
        wait_gnt(1'b1, g, gcyc);
        pkt_req = 4'b0010;
        n_vec++; if (g !== 4'b0001) begin n_err++; $display("FAIL gap_first: got %b want 0001", g); end
        send_packet(0, 9, 48, 0, lc);
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (b_busy !== 1'b1 || b_valid !== 1'b0) begin n_err++; $display("FAIL gap_busy: got busy=%b valid=%b want 1/0", b_busy, b_valid); end
        wait_gnt(1'b1, g, gcyc);
        pkt_req = 4'b0;
        n_vec++; if (b_eop_cyc != lc + 1) begin n_err++; $display("FAIL gap_eop: got +%0d want +1", b_eop_cyc - lc); end
        n_vec++; if (g !== 4'b0010 || gcyc - b_eop_cyc - 1 != 5) begin n_err++; $display("FAIL gap_len: got %b after %0d idle want 0010 after 5", g, gcyc - b_eop_cyc - 1); end
    endtask

    task automatic test_cc();
        logic [3:0] g; int gcyc, lc;
        do_reset();
        @(posedge clk); #1;
        pkt_req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(1'b0, g, gcyc);
            if (k == 2) pkt_req = 4'b0;
            clear_mon();
            send_packet(2, k, 48, 0, lc);
            n_vec++; if (a_data_log[1] !== exp_out(2, k, 2, k)) begin n_err++; $display("FAIL cc_word2_%0d: got %h want %h", k, a_data_log[1], exp_out(2, k, 2, k)); end
            n_vec++; if (a_errlen_cnt != 0) begin n_err++; $display("FAIL cc_err_%0d: got %0d want 0", k, a_errlen_cnt); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_len_err();
        test_timeout();
        test_gap();
        test_cc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ts_pkt_arb4.md
# ts_pkt_arb4

Packet-level round-robin arbiter that shares one 32-bit TS output stream among four TS packet sources. Each source raises a request when it holds a complete packet. The arbiter grants one source at a time and forwards exactly one packet of `PKT_WORDS` words from it. It regenerates clean sync/eop framing on the output and flags malformed or stalled packets. It sits between the per-channel TS generators/buffers and the 32-bit downstream TS datapath.

## Interface
- `U_DLY`, 1, register assignment delay (simulation only)
- `PKT_WORDS`, 48, 32-bit words per packet; legal range 2..255
- `GAP_CYCLES`, 0, idle cycles forced between packets; legal range 0..255
- `TIMEOUT`, 64, max consecutive cycles in XFER with no selected `in_valid` before abort; legal range 1..255
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `pkt_req`  in  4  bit i = source i holds a full packet (level)
- `pkt_gnt`  out  4  one-cycle one-hot grant pulse to the winner
- `in_sync`  in  4  per-source first-word strobe
- `in_valid`  in  4  per-source word valid
- `in_eop`  in  4  per-source last-word strobe
- `in_data`  in  128  source i occupies bits [32i+31:32i]
- `out_sync`  out  1  first word of output packet
- `out_valid`  out  1  output word valid
- `out_eop`  out  1  last word of output packet
- `out_data`  out  32  output word; 0 when `out_valid`=0
- `cur_src`  out  2  index of the source currently owning the output
- `busy`  out  1  high in GRANT, XFER and GAP
- `err_len`  out  1  one-cycle pulse on framing error
- `err_tmo`  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, GRANT, XFER, GAP.
- **IDLE**
  - If `pkt_req`≠0, select the winner round-robin, searching from `last+1` mod 4.
  - Register the winner into `cur_src`, pulse `pkt_gnt[cur_src]`, and go to GRANT.
- **GRANT**
  - Lasts exactly one cycle; `pkt_gnt` is high during it.
  - Clear the word counter `wcnt` and the stall counter.
  - Set `last` to `cur_src`, then go to XFER.
- **XFER**
  - Only the `cur_src` lane is observed; the other lanes are ignored.
  - Each cycle with `in_valid[cur_src]`=1 forwards one word and increments `wcnt` (8 bits).
  - Output framing is generated, not copied:
    - `out_sync` is asserted on output word 1.
    - `out_eop` is asserted on output word `PKT_WORDS`.
  - Framing error, which pulses `err_len`:
    - `in_sync` is absent on word 1, or asserted on any later word; or
    - `in_eop` is asserted on a word before `PKT_WORDS`, or absent on word `PKT_WORDS`.
  - On a framing error the packet still runs to `PKT_WORDS` words; no early termination.
  - When word `PKT_WORDS` is accepted: go to GAP if `GAP_CYCLES`>0, otherwise go to IDLE.
  - Stall counter:
    - Increments on every cycle with no valid word.
    - Resets on every valid word.
    - Reaching `TIMEOUT` pulses `err_tmo` and aborts. The output packet is left truncated with no `out_eop`; next state is GAP or IDLE as above.
- **GAP**
  - Counts `GAP_CYCLES` cycles, then goes to IDLE.
  - Requests arriving during GAP wait; arbitration happens only in IDLE.
- Simultaneous requests are resolved by the round-robin pointer only.
- A request deasserted after grant does not cancel the transfer.
- At reset `last`=3, so source 0 has highest priority on the first arbitration.
- Reset mid-packet: all state clears on the next clock edge. The output packet is truncated with no eop and no error pulse.

## Timing
- Reset values:
  - `pkt_gnt`=0, `out_sync`=0, `out_valid`=0, `out_eop`=0, `out_data`=0.
  - `cur_src`=0, `busy`=0, `err_len`=0, `err_tmo`=0.
  - FSM in IDLE, `last`=3.
- Request to grant: `pkt_gnt` is high in the cycle after `pkt_req` is sampled in IDLE.
- The source may present its first word from the cycle after `pkt_gnt`.
- Data latency is 1 cycle, and all outputs are registered:
  - `out_*` reflect the `in_*` word accepted on the previous edge.
  - `err_len` is asserted alongside the offending output word.
- Back-to-back best case, with `GAP_CYCLES`=0 and no stalls:
  - IDLE(1) + GRANT(1) + `PKT_WORDS` → 50 cycles per packet with `PKT_WORDS`=48.
  - The next grant pulse occurs 2 cycles after the last input word.

## Configuration
- Macro: `TS_ARB_CC_RESTAMP_EN`.
- Defined:
  - The arbiter keeps a 4-bit continuity counter per source, reset to 0.
  - On output word 2 of each forwarded packet, bits [3:0] are replaced by that source's counter.
  - The counter increments after each completed packet; aborted packets do not increment it.
- Undefined: data passes through unmodified and no counters are built.

## Test plan
- Single source, default parameters: `pkt_req`=4'b0001, source sends 48 words with correct sync/eop → `pkt_gnt`=4'b0001 for 1 cycle; 48 `out_valid` words with `out_sync` on word 1 and `out_eop` on word 48; no errors.
- All four sources request continuously → grants cycle in order 0,1,2,3,0 with `GAP_CYCLES`=0; each grant arrives 2 cycles after the previous packet's last input word.
- Source asserts `in_eop` on word 30 → `err_len` pulses once with output word 30; transfer continues to 48 words and `out_eop` on word 48.
- Source stalls after word 10 with `TIMEOUT`=8 → `err_tmo` pulses after 8 idle cycles; no `out_eop`; FSM returns to IDLE and the next request is granted.
- `GAP_CYCLES`=5 with two sources requesting → exactly 5 idle cycles between `out_eop` of the first packet and the next GRANT state.
- `TS_ARB_CC_RESTAMP_EN` defined, source 2 sends 3 packets with CC nibble 0xF → output word 2 bits [3:0] = 0, 1, 2.
